// File: rtl/divider_sweep_controller_pkg.sv
// Shared state encoding and ratio constants for the divider sweep controller.
package divider_sweep_controller_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    localparam int DEFAULT_N = 26;
    localparam int N_MIN     = 2;

endpackage

// File: rtl/sweep_table.sv
// Sweep table: DEPTH entries of {ratio, hold}, clamped on write, async-read.
// Latency: write lands on the next clock_in edge; read is combinational.
// Backpressure: none, a write is accepted every cycle in any controller state.
module sweep_table #(
    parameter int WIDTH      = 5,
    parameter int DEPTH      = 8,
    parameter int HOLD_WIDTH = 8,
    parameter int DEFAULT_N  = 26
) (
    input  logic                     clock_in,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_n,
    input  logic [HOLD_WIDTH-1:0]    wr_hold,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_n,
    output logic [HOLD_WIDTH-1:0]    rd_hold
);
    import divider_sweep_controller_pkg::*;

    localparam logic [WIDTH-1:0]      N_FLOOR = WIDTH'(N_MIN);
    localparam logic [HOLD_WIDTH-1:0] HOLD_1  = HOLD_WIDTH'(1);

    logic [WIDTH-1:0]      tbl_n    [DEPTH];
    logic [HOLD_WIDTH-1:0] tbl_hold [DEPTH];

    // A ratio below 2 or a zero hold would stall the divider, so clamp at the write port.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_n[i]    <= WIDTH'(DEFAULT_N);
                tbl_hold[i] <= HOLD_1;
            end
        end else if (we) begin
            tbl_n[wr_addr]    <= (wr_n < N_FLOOR) ? N_FLOOR : wr_n;
            tbl_hold[wr_addr] <= (wr_hold == '0) ? HOLD_1 : wr_hold;
        end
    end

    assign rd_n    = tbl_n[rd_addr];
    assign rd_hold = tbl_hold[rd_addr];

endmodule

// File: rtl/divider_sweep_controller.sv
// Steps a frequency_divider ratio through a programmed table, changing n only at period boundaries.
// Latency: n updates on the edge after the divider counter enters 0; done pulses on that same edge.
// Backpressure: none; start is ignored while busy, stop is held pending until the next boundary.
module divider_sweep_controller #(
    parameter int WIDTH      = 5,
    parameter int DEPTH      = 8,
    parameter int HOLD_WIDTH = 8,
    parameter int DEFAULT_N  = divider_sweep_controller_pkg::DEFAULT_N
) (
    input  logic                     clock_in,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [WIDTH-1:0]         cfg_n,
    input  logic [HOLD_WIDTH-1:0]    cfg_hold,
    input  logic [$clog2(DEPTH)-1:0] last_idx,
    input  logic                     loop_en,
    input  logic                     start,
    input  logic                     stop,
    input  logic [WIDTH-1:0]         counter,
    output logic [WIDTH-1:0]         n,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     busy,
    output logic                     done
);
    import divider_sweep_controller_pkg::*;

    localparam int              AW    = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] N_DEF = WIDTH'(DEFAULT_N);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [WIDTH-1:0]      counter_q;
    logic                  bnd;
    logic                  stop_pend;
    logic                  stop_any;
    logic [AW-1:0]         last_q;
    logic [AW-1:0]         rd_idx;
    logic [HOLD_WIDTH-1:0] hold_cnt;
    logic [HOLD_WIDTH-1:0] tbl_hold;
    logic [WIDTH-1:0]      tbl_n;
    logic                  do_load;
    logic                  do_dec;
    logic                  do_idle;
    logic                  do_done;

    assign bnd      = (counter == '0) && (counter_q != '0);
    assign stop_any = stop_pend | stop;

    sweep_table #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .HOLD_WIDTH (HOLD_WIDTH),
        .DEFAULT_N  (DEFAULT_N)
    ) u_table (
        .clock_in (clock_in),
        .reset    (reset),
        .we       (cfg_we),
        .wr_addr  (cfg_addr),
        .wr_n     (cfg_n),
        .wr_hold  (cfg_hold),
        .rd_addr  (rd_idx),
        .rd_n     (tbl_n),
        .rd_hold  (tbl_hold)
    );

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Natural completion outranks a pending stop so done is still reported.
    always_comb begin
        state_nxt = state;
        rd_idx    = '0;
        do_load   = 1'b0;
        do_dec    = 1'b0;
        do_idle   = 1'b0;
        do_done   = 1'b0;
        case (state)
            IDLE: if (start && !stop) state_nxt = ARM;
            ARM: if (bnd) begin
                if (stop_any) do_idle = 1'b1;
                else          do_load = 1'b1;
            end
            RUN: if (bnd) begin
                if (hold_cnt > HOLD_WIDTH'(1)) begin
                    if (stop_any) do_idle = 1'b1;
                    else          do_dec  = 1'b1;
                end else if (idx < last_q) begin
                    if (stop_any) do_idle = 1'b1;
                    else begin
                        do_load = 1'b1;
                        rd_idx  = idx + AW'(1);
                    end
                end else if (loop_en) begin
                    if (stop_any) do_idle = 1'b1;
                    else          do_load = 1'b1;
                end else begin
                    do_idle = 1'b1;
                    do_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (do_load) state_nxt = RUN;
        if (do_idle) state_nxt = IDLE;
    end

    always_comb begin
        busy = (state == ARM) || (state == RUN);
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            counter_q <= '0;
            n         <= N_DEF;
            idx       <= '0;
            hold_cnt  <= '0;
            last_q    <= '0;
            stop_pend <= 1'b0;
            done      <= 1'b0;
        end else begin
            counter_q <= counter;
            done      <= do_done;
            if (state == IDLE && start && !stop) last_q <= last_idx;
            if (state_nxt == IDLE) stop_pend <= 1'b0;
            else if (stop)         stop_pend <= 1'b1;
            if (do_load) begin
                n        <= tbl_n;
                hold_cnt <= tbl_hold;
                idx      <= rd_idx;
            end else if (do_dec) begin
                hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
            end else if (do_idle) begin
                n   <= N_DEF;
                idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_divider_sweep_controller.sv
// Bench: models the divider counter, scoreboards n/idx/busy/done and period length at each boundary.
module tb_divider_sweep_controller;

    logic       clock_in;
    logic       reset;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [4:0] cfg_n;
    logic [7:0] cfg_hold;
    logic [2:0] last_idx;
    logic       loop_en;
    logic       start;
    logic       stop;
    logic [4:0] counter;
    logic [4:0] n;
    logic [2:0] idx;
    logic       busy;
    logic       done;

    logic [4:0] cnt_prev;
    logic       tb_bnd;
    int         since;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string tag;
        int    n;
        int    idx;
        int    busy;
        int    done;
        int    gap;
    } exp_t;

    exp_t sb[$];

    divider_sweep_controller dut (
        .clock_in (clock_in),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_n    (cfg_n),
        .cfg_hold (cfg_hold),
        .last_idx (last_idx),
        .loop_en  (loop_en),
        .start    (start),
        .stop     (stop),
        .counter  (counter),
        .n        (n),
        .idx      (idx),
        .busy     (busy),
        .done     (done)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    assign tb_bnd = (counter == 5'd0) && (cnt_prev != 5'd0);

    // Divider model: counts 0..n-1; since = cycles elapsed since the last boundary.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            counter  <= 5'd0;
            cnt_prev <= 5'd0;
            since    <= 0;
        end else begin
            cnt_prev <= counter;
            counter  <= (counter >= n - 5'd1) ? 5'd0 : counter + 5'd1;
            since    <= tb_bnd ? 1 : since + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input int en, input int ei,
                        input int eb, input int ed, input int eg);
        exp_t e;
        e.tag  = tag;
        e.n    = en;
        e.idx  = ei;
        e.busy = eb;
        e.done = ed;
        e.gap  = eg;
        sb.push_back(e);
    endtask

    task automatic seek_bnd();
        int waited = 0;
        while (!tb_bnd && waited < 200) begin
            @(negedge clock_in);
            waited++;
        end
        if (!tb_bnd) chk("bnd_timeout", waited, 0);
    endtask

    task automatic expect_next();
        exp_t e;
        int   gap;
        e = sb.pop_front();
        seek_bnd();
        gap = since;
        @(negedge clock_in);
        chk({e.tag, ".n"},    int'(n),    e.n);
        chk({e.tag, ".idx"},  int'(idx),  e.idx);
        chk({e.tag, ".busy"}, int'(busy), e.busy);
        chk({e.tag, ".done"}, int'(done), e.done);
        chk({e.tag, ".gap"},  gap,        e.gap);
    endtask

    task automatic drain();
        while (sb.size() > 0) expect_next();
    endtask

    task automatic write_entry(input int a, input int wn, input int wh);
        cfg_we   = 1'b1;
        cfg_addr = 3'(a);
        cfg_n    = 5'(wn);
        cfg_hold = 8'(wh);
        @(negedge clock_in);
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_start(input int li, input int le);
        last_idx = 3'(li);
        loop_en  = le[0];
        start    = 1'b1;
        @(negedge clock_in);
        start    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = 3'd0;
        cfg_n    = 5'd0;
        cfg_hold = 8'd0;
        last_idx = 3'd0;
        loop_en  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        #2;
        chk("rst.n",    int'(n),    26);
        chk("rst.idx",  int'(idx),  0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        @(negedge clock_in);
        reset = 1'b0;

        // Basic two-entry sweep
        write_entry(0, 4, 2);
        write_entry(1, 6, 1);
        pulse_start(1, 0);
        chk("arm.busy", int'(busy), 1);
        chk("arm.n",    int'(n),    26);
        push("basic0", 4, 0, 1, 0, 26);
        push("basic1", 4, 0, 1, 0, 4);
        push("basic2", 6, 1, 1, 0, 4);
        push("basic3", 26, 0, 0, 1, 6);
        drain();
        @(negedge clock_in);
        chk("basic.done_once", int'(done), 0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        stop  = 1'b0;
        chk("ss.busy", int'(busy), 0);
        push("ss_idle", 26, 0, 0, 0, 26);
        drain();

        // Clamped single entry, looping
        write_entry(0, 1, 0);
        pulse_start(0, 1);
        push("clamp0", 2, 0, 1, 0, 26);
        for (int i = 1; i <= 4; i++) push($sformatf("clamp%0d", i), 2, 0, 1, 0, 2);
        drain();
        seek_bnd();
        stop = 1'b1;
        push("loop_stop", 26, 0, 0, 0, 2);
        drain();
        stop = 1'b0;

        // Abort mid-period
        write_entry(0, 6, 3);
        pulse_start(0, 0);
        push("abort0", 6, 0, 1, 0, 26);
        drain();
        @(negedge clock_in);
        @(negedge clock_in);
        stop = 1'b1;
        @(negedge clock_in);
        stop = 1'b0;
        chk("abort.n_held", int'(n),    6);
        chk("abort.busy",   int'(busy), 1);
        push("abort1", 26, 0, 0, 0, 6);
        drain();
        @(negedge clock_in);
        chk("abort.done", int'(done), 0);

        // stop coincident with the final boundary: completion wins
        write_entry(0, 4, 1);
        pulse_start(0, 0);
        push("coin0", 4, 0, 1, 0, 26);
        drain();
        seek_bnd();
        stop = 1'b1;
        push("coin1", 26, 0, 0, 1, 4);
        drain();
        stop = 1'b0;

        // Rewrite of the active entry applies on its next load
        write_entry(0, 4, 2);
        pulse_start(0, 1);
        push("live0", 4, 0, 1, 0, 26);
        drain();
        write_entry(0, 8, 2);
        push("live1", 4, 0, 1, 0, 4);
        push("live2", 8, 0, 1, 0, 4);
        push("live3", 8, 0, 1, 0, 8);
        drain();
        stop = 1'b1;
        @(negedge clock_in);
        stop = 1'b0;
        push("live4", 26, 0, 0, 0, 8);
        drain();

        // Asynchronous reset mid-sweep clears state and table
        pulse_start(0, 1);
        push("rs0", 8, 0, 1, 0, 26);
        drain();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid.n",    int'(n),    26);
        chk("rst_mid.idx",  int'(idx),  0);
        chk("rst_mid.busy", int'(busy), 0);
        chk("rst_mid.done", int'(done), 0);
        @(negedge clock_in);
        reset = 1'b0;
        pulse_start(0, 0);
        push("rs1", 26, 0, 1, 0, 26);
        push("rs2", 26, 0, 0, 1, 26);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/divider_sweep_controller.md
Name: divider_sweep_controller

Overview:
Sequencer that drives the `n` ratio input of frequency_divider through a programmed sweep of division ratios. Each ratio is held for a programmed number of divider periods. Every ratio change is applied only at a divider period boundary, so clock_out never sees a truncated or glitched period. The block sits between the configuration/control logic and one frequency_divider instance, and shares clock_in with it.

Parameters:
WIDTH, 5, width of n and of the divider counter
DEPTH, 8, number of sweep table entries (power of two)
HOLD_WIDTH, 8, width of the per-entry hold count (divider periods)
DEFAULT_N, 26, ratio driven while idle and after reset

Ports:
clock_in  input  1  system clock, same clock as frequency_divider
reset  input  1  asynchronous, active-high reset
cfg_we  input  1  table write strobe
cfg_addr  input  log2(DEPTH)  table entry index
cfg_n  input  WIDTH  ratio to store
cfg_hold  input  HOLD_WIDTH  periods to hold this ratio
last_idx  input  log2(DEPTH)  last table entry of the sweep, sampled on start
loop_en  input  1  1 = restart at entry 0 after last_idx
start  input  1  single-cycle sweep start request
stop  input  1  single-cycle abort request
counter  input  WIDTH  frequency_divider counter output
n  output  WIDTH  ratio to frequency_divider, registered
idx  output  log2(DEPTH)  active table entry
busy  output  1  high in ARM and RUN
done  output  1  one-cycle pulse on natural sweep completion

Behaviour:
- Clock and reset: one clock, clock_in. Reset is asynchronous and active-high.
- Reset values:
  - n=DEFAULT_N, idx=0, busy=0, done=0, state=IDLE.
  - Every table entry resets to n=DEFAULT_N, hold=1.
  - The boundary detector's previous-counter register resets to 0.
- Boundary: `bnd` = (counter==0) && (counter_q!=0), where counter_q is counter registered on the previous clock_in. All n updates take effect on the clock_in edge that samples `bnd`=1, so n changes one cycle after counter enters 0.
- Table writes:
  - cfg_we writes {cfg_n, cfg_hold} to cfg_addr on the next edge, in any state.
  - A stored cfg_n<2 is clamped to 2. A stored cfg_hold=0 is stored as 1.
  - A write to the active entry does not affect the running hold count; the new value is used the next time that entry is loaded.
- FSM states: IDLE, ARM, RUN.
  - IDLE: n=DEFAULT_N. start=1 and stop=0 -> ARM, capture last_idx into last_q. start while busy is ignored.
  - ARM: on `bnd`, load n<=table[0].n, hold_cnt<=table[0].hold, idx<=0 -> RUN.
  - RUN, on `bnd`:
    - hold_cnt>1: decrement.
    - hold_cnt==1 and idx<last_q: idx+1, load that entry's n and hold.
    - hold_cnt==1 and idx==last_q and loop_en=1: idx<=0, load entry 0.
    - hold_cnt==1 and idx==last_q and loop_en=0: n<=DEFAULT_N, idx<=0, done=1 for one cycle -> IDLE.
  - Without `bnd`, the RUN state holds all registers.
- Periods per entry: an entry is active for exactly hold full divider periods.
- stop: in ARM or RUN, stop sets stop_pend.
  - At the next `bnd`: n<=DEFAULT_N, idx<=0 -> IDLE, done stays 0.
  - stop in the same cycle as `bnd` takes effect on that boundary.
  - stop in IDLE has no effect. start and stop together in IDLE: remain IDLE.
- Simultaneous events: if `bnd` coincides with natural completion and stop, completion wins and done=1.
- loop_en is sampled live at each last-entry boundary. last_idx is sampled only on start.
- Reset mid-sweep: asynchronous return to the full reset state. The table contents are lost.

Decomposition:
- Shared package: state encoding localparams (IDLE=2'd0, ARM=2'd1, RUN=2'd2), DEFAULT_N, N_MIN=2.
- One sub-module, `sweep_table`: DEPTH x (WIDTH+HOLD_WIDTH) register file with an asynchronous reset, one synchronous write port (applying the clamps) and one combinational read port indexed by the next idx.
- The FSM, hold counter and boundary detector live in the top module.

Test Plan:
- Reset: assert reset mid-cycle -> n=26, busy=0, done=0, idx=0 immediately, without waiting for a clock edge.
- Basic sweep:
  - Stimulus: table {0:(n=4, hold=2), 1:(n=6, hold=1)}, last_idx=1, loop_en=0, start.
  - Response: n=4 from the first boundary, two 4-periods, then one 6-period.
  - At the final boundary: done pulses once and n returns to 26.
- Loop and clamp:
  - Stimulus: write cfg_n=1, cfg_hold=0 to entry 0, last_idx=0, loop_en=1.
  - Response: n=2, hold 1, repeating indefinitely with busy=1 and done never high.
- Abort: stop asserted mid-period in RUN -> n unchanged until the next counter 0 entry, then n=26, IDLE, done=0. Also start+stop together in IDLE -> stays IDLE.
- Boundary coincidence: stop on the same cycle as the final boundary with loop_en=0 -> done=1, IDLE.
- Live write: rewrite the active entry 0 from n=4 to n=8 while in RUN -> the current hold still runs at 4, and the next load of entry 0 (loop) gives 8.
